// File: rtl/ifid_ctrl.sv
// ifid_ctrl: instruction fetch/decode controller for the AZ datapath.
// Holds a writable instruction memory and a program counter, walks the
// program through FETCH -> DECODE -> HOLD, and hands each decoded
// instruction (opcode on control_bus, immediate on data) to the execute
// stage over a valid/ready handshake. Fetching past the loaded program
// space parks the controller in HALT until a jump redirects it.
module ifid_ctrl #(
  parameter  int INST_CAP = 20,
  parameter  int OPC_LEN  = 4,
  parameter  int DATA_LEN = 8,
  localparam int INST_LEN = OPC_LEN + DATA_LEN,
  localparam int PC_W     = $clog2(INST_CAP) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                wr_en,
  input  logic [PC_W-1:0]     wr_addr,
  input  logic [INST_LEN-1:0] wr_inst,
  input  logic                jmp,
  input  logic [PC_W-1:0]     jmp_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPC_LEN-1:0]  control_bus,
  output logic [DATA_LEN-1:0] data,
  output logic [PC_W-1:0]     pc_out,
  output logic                halt
);

  // Memory index width; PC_W carries one extra bit so pc can sit past the
  // end of the program without wrapping back into it.
  localparam int AW = PC_W - 1;
  localparam logic [PC_W-1:0] CAP_PC = PC_W'(INST_CAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_HOLD,
    S_HALT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PC_W-1:0]     pc;
  logic [INST_LEN-1:0] inst_reg;
  logic [INST_LEN-1:0] mem [INST_CAP];

  logic pc_oob;     // pc points past the loaded program space
  logic wr_ok;      // write address lands inside the memory
  logic load_inst;  // FETCH: capture mem[pc]
  logic present;    // DECODE: drive outputs, advance pc, raise valid
  logic accept;     // HOLD: downstream took the instruction
  logic idle_jmp;   // IDLE: redirect pc
  logic halt_set;   // FETCH with pc out of range
  logic resume;     // HALT: jump releases the halt

  assign pc_oob = (pc >= CAP_PC);
  assign wr_ok  = wr_en && (wr_addr < CAP_PC);

  // Instruction memory write port, live in every state and across reset.
  // NOTE: storage is deliberately left out of reset -- a program loaded before
  // reset must survive it, and a reset on an array blocks RAM inference.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr[AW-1:0]] <= wr_inst;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, whatever block order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: state_nxt is given a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (en) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = pc_oob ? S_HALT : S_DECODE;
      S_DECODE: state_nxt = S_HOLD;
      S_HOLD:   if (out_ready) state_nxt = en ? S_FETCH : S_IDLE;
      S_HALT:   if (jmp) state_nxt = en ? S_FETCH : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Per-state datapath commands; jmp only matters in IDLE, HALT and on an
  // accepting handshake in HOLD.
  always_comb begin
    load_inst = 1'b0;
    present   = 1'b0;
    accept    = 1'b0;
    idle_jmp  = 1'b0;
    halt_set  = 1'b0;
    resume    = 1'b0;
    case (state)
      S_IDLE:   idle_jmp = jmp;
      S_FETCH: begin
        halt_set  = pc_oob;
        load_inst = !pc_oob;
      end
      S_DECODE: present = 1'b1;
      S_HOLD:   accept = out_ready;
      S_HALT:   resume = jmp;
      default: ;
    endcase
  end

  // Datapath registers: pc, fetched word and the registered outputs, which
  // only change in DECODE so they stay bit-stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc          <= '0;
      inst_reg    <= '0;
      control_bus <= '0;
      data        <= '0;
      pc_out      <= '0;
      out_valid   <= 1'b0;
      halt        <= 1'b0;
    end else begin
      // Read-before-write falls out of sampling mem ahead of this edge's write.
      if (load_inst) begin
        inst_reg <= mem[pc[AW-1:0]];
      end
      if (present) begin
        control_bus <= inst_reg[INST_LEN-1:DATA_LEN];
        data        <= inst_reg[DATA_LEN-1:0];
        pc_out      <= pc;
        pc          <= pc + PC_W'(1);
        out_valid   <= 1'b1;
      end
      if (accept) begin
        out_valid <= 1'b0;
        if (jmp) begin
          pc <= jmp_addr;
        end
      end
      if (idle_jmp) begin
        pc <= jmp_addr;
      end
      if (halt_set) begin
        halt <= 1'b1;
      end
      if (resume) begin
        halt <= 1'b0;
        pc   <= jmp_addr;
      end
    end
  end

endmodule

// File: tb/tb_ifid_ctrl.sv
// Testbench for ifid_ctrl: directed scenarios followed by randomized traffic,
// all compared every cycle against a timing-level reference model.
module tb_ifid_ctrl;

  localparam int CAP = 20;
  localparam int PW  = 6;
  localparam int IL  = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          wr_en = 1'b0;
  logic [PW-1:0] wr_addr = '0;
  logic [IL-1:0] wr_inst = '0;
  logic          jmp = 1'b0;
  logic [PW-1:0] jmp_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    control_bus;
  logic [7:0]    data;
  logic [PW-1:0] pc_out;
  logic          halt;

  int n_checks = 0;
  int n_fail   = 0;

  ifid_ctrl #(.INST_CAP(CAP), .OPC_LEN(4), .DATA_LEN(8)) dut (
    .clk(clk), .rstn(rstn), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_inst(wr_inst), .jmp(jmp), .jmp_addr(jmp_addr), .out_valid(out_valid),
    .out_ready(out_ready), .control_bus(control_bus), .data(data),
    .pc_out(pc_out), .halt(halt)
  );

  always #5 clk = ~clk;

  // Reference model: instead of FSM states it tracks how many edges remain
  // until the in-flight instruction is shown (2 = word not yet read,
  // 1 = word read, 0 = nothing in flight), plus valid/halt flags.
  int m_mem [CAP];
  int m_pc = 0, m_cd = 0, m_word = 0, m_cb = 0, m_d = 0, m_pco = 0;
  bit m_valid = 1'b0, m_halt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the current inputs, let the DUT take the
  // edge, compare every output, then return at the falling edge.
  task automatic tick();
    int n_pc = m_pc, n_cd = m_cd, n_word = m_word;
    int n_cb = m_cb, n_d = m_d, n_pco = m_pco;
    bit n_valid = m_valid, n_halt = m_halt;
    if (!rstn) begin
      n_pc = 0; n_cd = 0; n_word = 0; n_cb = 0; n_d = 0; n_pco = 0;
      n_valid = 1'b0; n_halt = 1'b0;
    end else if (m_halt) begin
      if (jmp) begin
        n_pc = int'(jmp_addr); n_halt = 1'b0; n_cd = en ? 2 : 0;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        n_valid = 1'b0;
        if (jmp) n_pc = int'(jmp_addr);
        n_cd = en ? 2 : 0;
      end
    end else if (m_cd == 2) begin
      if (m_pc >= CAP) begin
        n_halt = 1'b1; n_cd = 0;
      end else begin
        n_word = m_mem[m_pc]; n_cd = 1;
      end
    end else if (m_cd == 1) begin
      n_cb = (m_word >> 8) & 'hF; n_d = m_word & 'hFF; n_pco = m_pc;
      n_pc = m_pc + 1; n_valid = 1'b1; n_cd = 0;
    end else begin
      if (jmp) n_pc = int'(jmp_addr);
      if (en) n_cd = 2;
    end
    // Memory update after any read above: a same-edge fetch sees the old word.
    if (wr_en && int'(wr_addr) < CAP) m_mem[int'(wr_addr)] = int'(wr_inst);
    @(posedge clk);
    #1;
    m_pc = n_pc; m_cd = n_cd; m_word = n_word; m_cb = n_cb; m_d = n_d;
    m_pco = n_pco; m_valid = n_valid; m_halt = n_halt;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("halt", 32'(halt), 32'(m_halt));
    check("control_bus", 32'(control_bus), 32'(m_cb));
    check("data", 32'(data), 32'(m_d));
    check("pc_out", 32'(pc_out), 32'(m_pco));
    @(negedge clk);
  endtask

  // Tick until out_valid rises, within a fixed budget; n = ticks taken.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic expect_inst(input string tag, input int cb, input int d, input int pc);
    check({tag, "_cb"}, 32'(control_bus), 32'(cb));
    check({tag, "_data"}, 32'(data), 32'(d));
    check({tag, "_pc"}, 32'(pc_out), 32'(pc));
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    // Reset, then load the whole program with fetching disabled.
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      wr_en   = 1'b1;
      wr_addr = PW'(i);
      wr_inst = (i == 0) ? 12'hA05 : (i == 1) ? 12'h3FF : (i == 2) ? 12'h000
                                   : IL'($urandom);
      tick();
    end
    // Out-of-range write must be dropped (model ignores it too).
    wr_addr = PW'(CAP + 3);
    wr_inst = 12'hBAD;
    tick();
    wr_en = 1'b0;

    // Sequential flow with out_ready held high.
    en = 1'b1; out_ready = 1'b1;
    reset_pulse();
    wait_valid("seq0", n);
    expect_inst("seq0", 'hA, 'h05, 0);
    tick();
    wait_valid("seq1", n);
    check("seq_throughput", 32'(n), 32'd2);
    expect_inst("seq1", 'h3, 'hFF, 1);
    tick();
    wait_valid("seq2", n);
    expect_inst("seq2", 'h0, 'h00, 2);

    // Backpressure: five stalled cycles, outputs frozen.
    out_ready = 1'b0;
    reset_pulse();
    wait_valid("bp", n);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_inst("bp_hold", 'hA, 'h05, 0);
    end
    out_ready = 1'b1;
    tick();
    wait_valid("bp_next", n);
    check("bp_latency", 32'(n), 32'd2);
    expect_inst("bp_next", 'h3, 'hFF, 1);

    // Jump on the first handshake, then jmp pulsed in FETCH/DECODE is ignored.
    reset_pulse();
    wait_valid("jmp0", n);
    jmp = 1'b1; jmp_addr = PW'(2);
    tick();
    jmp = 1'b0;
    wait_valid("jmp_tgt", n);
    check("jmp_penalty", 32'(n), 32'd2);
    expect_inst("jmp_tgt", 'h0, 'h00, 2);
    tick();
    jmp = 1'b1; jmp_addr = PW'(10);
    tick();
    tick();
    jmp = 1'b0;
    check("jmp_ignored_valid", 32'(out_valid), 32'd1);
    check("jmp_ignored_pc", 32'(pc_out), 32'd3);

    // Run off the end of the program into HALT, then resume by jump.
    jmp = 1'b1; jmp_addr = PW'(CAP - 2);
    tick();
    jmp = 1'b0;
    wait_valid("tail0", n);
    check("tail0_pc", 32'(pc_out), 32'(CAP - 2));
    tick();
    wait_valid("tail1", n);
    check("tail1_pc", 32'(pc_out), 32'(CAP - 1));
    tick();
    tick();
    check("halt_rise", 32'(halt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_stay", 32'(halt), 32'd1);
      check("halt_novalid", 32'(out_valid), 32'd0);
    end
    jmp = 1'b1; jmp_addr = PW'(1);
    tick();
    jmp = 1'b0;
    check("halt_fall", 32'(halt), 32'd0);
    wait_valid("resume", n);
    check("resume_latency", 32'(n), 32'd2);
    expect_inst("resume", 'h3, 'hFF, 1);

    // Write to pc=1 on the same edge FETCH reads it: old word first.
    reset_pulse();
    wait_valid("rbw0", n);
    tick();
    wr_en = 1'b1; wr_addr = PW'(1); wr_inst = 12'h777;
    tick();
    wr_en = 1'b0;
    wait_valid("rbw_old", n);
    expect_inst("rbw_old", 'h3, 'hFF, 1);
    jmp = 1'b1; jmp_addr = PW'(1);
    tick();
    jmp = 1'b0;
    wait_valid("rbw_new", n);
    expect_inst("rbw_new", 'h7, 'h77, 1);

    // Reset mid-handshake clears outputs but keeps the program.
    out_ready = 1'b0;
    rstn = 1'b0;
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    expect_inst("rst_out", 0, 0, 0);
    rstn = 1'b1; out_ready = 1'b1;
    wait_valid("rst_mem", n);
    expect_inst("rst_mem", 'hA, 'h05, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rstn      = ($urandom_range(0, 199) != 0);
      en        = ($urandom_range(0, 99) < 85);
      out_ready = ($urandom_range(0, 99) < 60);
      jmp       = ($urandom_range(0, 99) < 8);
      jmp_addr  = ($urandom_range(0, 9) == 0) ? PW'($urandom_range(CAP, 63))
                                              : PW'($urandom_range(0, CAP - 1));
      wr_en     = ($urandom_range(0, 99) < 10);
      wr_addr   = PW'($urandom_range(0, CAP + 5));
      wr_inst   = IL'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
